riscv_regfile_sb: RTL and testbench
===================================

// Module: riscv_regfile_sb
// PURPOSE
//  Parametrised RISC-V integer register file with NRD combinational read ports, one write-back port,
//  write-through bypass and a per-register busy scoreboard for the pipelined core. Sits between
//  decode (reads, issue) and write-back (retire); replaces the single-cycle file of the first core.
// PARAMETERS
//  XLEN   32  data width in bits
//  NREGS  32  number of architectural registers (power of 2, >=2); x0 is hardwired zero
//  NRD    2   number of read ports (1..4)
//  AW     $clog2(NREGS)  register-address width (derived, localparam)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  rs_addr    in   NRD*AW     packed read addresses, port i = [i*AW +: AW]
//  rs_data    out  NRD*XLEN   packed read data, port i = [i*XLEN +: XLEN]
//  rs_busy    out  NRD        port i source has an outstanding write (RAW hazard)
//  issue_vld  in   1          decode requests to mark issue_rd as pending
//  issue_rd   in   AW         destination of issuing instruction
//  issue_rdy  out  1          issue accepted this cycle (no WAW on issue_rd)
//  wb_en      in   1          write-back valid; writes register and retires pending bit
//  wb_addr    in   AW         write-back destination
//  wb_data    in   XLEN       write-back value
//  busy_cnt   out  AW+1       number of registers currently marked busy
// BEHAVIOUR
//  Reset (async, rst_n=0): all registers <= 0, all busy bits <= 0, busy_cnt <= 0; outputs settle
//   combinationally: rs_data=0, rs_busy=0, issue_rdy=1. Reset mid-operation discards all pending state.
//  Write: on clk rise with wb_en=1 and wb_addr!=0, regs[wb_addr] <= wb_data. wb_addr=0 ignored.
//  Read (0-cycle latency, combinational): rs_addr=0 -> 0. Else if wb_en && wb_addr==rs_addr -> wb_data
//   (write-through bypass). Else regs[rs_addr]. All NRD ports independent; same address on
//   several ports is legal.
//  Scoreboard: busy[NREGS-1:0], busy[0] constant 0.
//   rs_busy[i] = busy[a_i] && !(wb_en && wb_addr==a_i), a_i = port-i address (bypass clears hazard).
//   issue_rdy = !issue_vld || issue_rd==0 || !busy[issue_rd] || (wb_en && wb_addr==issue_rd).
//   Issue accepted = issue_vld && issue_rdy && issue_rd!=0 -> busy[issue_rd] <= 1 next edge.
//   Retire: wb_en && wb_addr!=0 -> busy[wb_addr] <= 0, unless accepted issue to same reg in the
//   same cycle, in which case busy stays 1 (set wins; new producer outstanding).
//   wb_en to a non-busy register is legal (write without scoreboard) and leaves busy unchanged.
//   Issue with issue_rdy=0 is dropped; decode must hold and retry (stall). No state changes.
//  busy_cnt: registered; +1 on accepted issue to non-busy reg, -1 on retire of busy reg, net 0 when
//   both on same reg or one of each on different regs; never wraps (max NREGS-1, min 0).
//  Out-of-range addresses impossible (NREGS power of 2). No X on outputs after reset.
// TESTING
//  Reset: drive rst_n=0 mid-clock with regs/busy populated -> all rs_data=0, busy_cnt=0 immediately.
//  Basic ALU path: wb x1=10, x2=20 on two edges; rs_addr={x2,x1} -> rs_data={20,10}; wb x3=30 -> read x3=30.
//  Bypass: wb_en, wb_addr=5, wb_data=0xDEADBEEF same cycle as rs_addr[0]=5 -> rs_data[0]=0xDEADBEEF, rs_busy[0]=0.
//  x0: wb x0=0x1234; issue_rd=0 -> read x0=0, issue_rdy=1, busy_cnt unchanged.
//  Scoreboard: issue x7 -> next cycle rs_busy on x7=1, busy_cnt=1; issue x7 again -> issue_rdy=0;
//   wb x7=42 -> rs_busy=0 same cycle, busy_cnt=0 next edge, read x7=42.
//  Simultaneous: x9 busy, wb x9 and issue x9 same cycle -> issue_rdy=1, busy[9] stays 1, busy_cnt=1, regs[9]=wb_data.

Source files
------------

// File: rtl/riscv_regfile_sb.sv
// riscv_regfile_sb
// RISC-V integer register file for the pipelined core: NRD combinational read
// ports with write-through bypass from the single write-back port, x0 hardwired
// to zero, and a per-register busy scoreboard that flags RAW hazards on reads
// and blocks WAW on issue. busy_cnt tracks how many producers are outstanding.
module riscv_regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                issue_vld,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_rdy,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    output logic [AW:0]         busy_cnt
);

    // Largest count the scoreboard can ever reach: every register but x0.
    localparam logic [AW:0] CNT_MAX = (AW+1)'(NREGS - 1);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    // Architectural state.
    logic [XLEN-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_busy_cnt;

    // Write-back / issue decode.
    logic             w_retire;
    logic             w_wb_hits_issue;
    logic             w_issue_acc;
    logic             w_cnt_inc;
    logic             w_cnt_dec;
    logic [NREGS-1:0] w_busy_nxt;

    // Saturating busy counter step; the guards keep the count from wrapping
    // even if the surrounding logic were ever driven out of its legal range.
    function automatic logic [AW:0] f_cnt_step(input logic [AW:0] cnt,
                                               input logic        inc,
                                               input logic        dec);
        logic [AW:0] nxt;
        nxt = cnt;
        if (inc && !dec) begin
            nxt = (cnt >= CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
        end else if (dec && !inc) begin
            nxt = (cnt == '0) ? '0 : cnt - CNT_ONE;
        end
        return nxt;
    endfunction

    assign w_retire        = wb_en && (wb_addr != '0);
    assign w_wb_hits_issue = wb_en && (wb_addr == issue_rd);

    // A WAW stall only happens when the target is busy and is not being
    // retired right now; retiring producer frees the slot in the same cycle.
    assign issue_rdy = !issue_vld || (issue_rd == '0) || !r_busy[issue_rd] ||
                       w_wb_hits_issue;

    assign w_issue_acc = issue_vld && issue_rdy && (issue_rd != '0);

    // Count moves only when a busy bit actually changes: a new producer on an
    // idle register, or a retire of a busy register not immediately re-issued.
    assign w_cnt_inc = w_issue_acc && !r_busy[issue_rd];
    assign w_cnt_dec = w_retire && r_busy[wb_addr] &&
                       !(w_issue_acc && (issue_rd == wb_addr));

    // Next scoreboard: retire clears, accepted issue sets, set wins on a tie.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_retire) begin
            w_busy_nxt[wb_addr] = 1'b0;
        end
        if (w_issue_acc) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Register array write port; x0 is never written and stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_retire) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Scoreboard busy bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Outstanding-producer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_cnt <= '0;
        end else begin
            r_busy_cnt <= f_cnt_step(r_busy_cnt, w_cnt_inc, w_cnt_dec);
        end
    end

    assign busy_cnt = r_busy_cnt;

    // Read ports: x0 reads zero, a same-cycle write-back is forwarded and
    // also clears the hazard since the value is now available.
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_hit;
        assign w_addr = rs_addr[g*AW +: AW];
        assign w_hit  = wb_en && (wb_addr == w_addr);
        assign rs_data[g*XLEN +: XLEN] = (w_addr == '0) ? '0 :
                                         w_hit          ? wb_data :
                                                          r_regs[w_addr];
        assign rs_busy[g] = r_busy[w_addr] && !w_hit;
    end

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// tb_riscv_regfile_sb
// Directed bench for riscv_regfile_sb (32 x 32-bit, 2 read ports). A
// behavioural model of the register contents and busy set is compared with the
// DUT on every falling edge; literal expectations along the way pin the model.
module tb_riscv_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                rst_n;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                issue_vld;
    logic [AW-1:0]       issue_rd;
    logic                issue_rdy;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic [AW:0]         busy_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_addr   (rs_addr),
        .rs_data   (rs_data),
        .rs_busy   (rs_busy),
        .issue_vld (issue_vld),
        .issue_rd  (issue_rd),
        .issue_rdy (issue_rdy),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    logic             m_acc;
    logic [NREGS-1:0] m_clr;
    logic [NREGS-1:0] m_set;

    assign m_acc = issue_vld && (issue_rd != 0) &&
                   (!m_busy[issue_rd] || (wb_en && wb_addr == issue_rd));
    assign m_clr = (wb_en && wb_addr != 0) ? (32'd1 << wb_addr) : 32'd0;
    assign m_set = m_acc ? (32'd1 << issue_rd) : 32'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] <= '0;
            m_busy <= '0;
        end else begin
            if (wb_en && wb_addr != 0) m_regs[wb_addr] <= wb_data;
            m_busy <= (m_busy & ~m_clr) | m_set;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs are combinational from inputs changed at posedge+1.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < NRD; p++) begin
                logic [AW-1:0]   a;
                logic            hit;
                logic [XLEN-1:0] ed;
                a   = rs_addr[p*AW +: AW];
                hit = wb_en && (wb_addr == a);
                ed  = (a == 0) ? '0 : (hit ? wb_data : m_regs[a]);
                chk($sformatf("model rs_data[%0d]", p), 64'(rs_data[p*XLEN +: XLEN]), 64'(ed));
                chk($sformatf("model rs_busy[%0d]", p), 64'(rs_busy[p]),
                    64'(m_busy[a] && !hit));
            end
            chk("model issue_rdy", 64'(issue_rdy),
                64'(!issue_vld || issue_rd == 0 || !m_busy[issue_rd] ||
                    (wb_en && wb_addr == issue_rd)));
            chk("model busy_cnt", 64'(busy_cnt), 64'($countones(m_busy)));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        issue_vld = 1'b0; issue_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input int a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = AW'(a); wb_data = d;
    endtask

    task automatic iss(input int a);
        issue_vld = 1'b1; issue_rd = AW'(a);
    endtask

    initial begin
        rst_n = 1'b0;
        rs_addr = '0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        rs_addr = {5'd2, 5'd1};
        #1;
        chk("reset rs_data", 64'(rs_data), 64'd0);
        chk("reset rs_busy", 64'(rs_busy), 64'd0);
        chk("reset busy_cnt", 64'(busy_cnt), 64'd0);
        chk("reset issue_rdy", 64'(issue_rdy), 64'd1);

        // basic writes and reads
        wb(1, 32'd10); tick();
        wb(2, 32'd20); tick();
        idle(); #1;
        chk("read x2,x1", 64'(rs_data), {32'd20, 32'd10});
        wb(3, 32'd30); tick();
        idle(); rs_addr = {5'd2, 5'd3}; #1;
        chk("read x3", 64'(rs_data[31:0]), 64'd30);

        // bypass
        wb(5, 32'hDEADBEEF); rs_addr = {5'd1, 5'd5}; #1;
        chk("bypass data", 64'(rs_data[31:0]), 64'hDEADBEEF);
        chk("bypass busy", 64'(rs_busy[0]), 64'd0);
        chk("bypass other port", 64'(rs_data[63:32]), 64'd10);
        tick(); idle();

        // x0
        wb(0, 32'h1234); iss(0); rs_addr = {5'd0, 5'd0}; #1;
        chk("x0 bypass", 64'(rs_data), 64'd0);
        chk("x0 issue_rdy", 64'(issue_rdy), 64'd1);
        tick(); idle(); #1;
        chk("x0 after write", 64'(rs_data), 64'd0);
        chk("x0 busy_cnt", 64'(busy_cnt), 64'd0);

        // scoreboard on x7
        iss(7); rs_addr = {5'd0, 5'd7}; #1;
        chk("x7 issue_rdy", 64'(issue_rdy), 64'd1);
        tick(); #1;
        chk("x7 rs_busy", 64'(rs_busy), 64'b01);
        chk("x7 busy_cnt", 64'(busy_cnt), 64'd1);
        chk("x7 waw stall", 64'(issue_rdy), 64'd0);
        tick(); #1;
        chk("x7 dropped cnt", 64'(busy_cnt), 64'd1);
        issue_vld = 1'b0; wb(7, 32'd42); #1;
        chk("x7 wb hazard clear", 64'(rs_busy), 64'd0);
        chk("x7 wb bypass", 64'(rs_data[31:0]), 64'd42);
        tick(); idle(); #1;
        chk("x7 retired cnt", 64'(busy_cnt), 64'd0);
        chk("x7 read", 64'(rs_data[31:0]), 64'd42);

        // simultaneous issue + retire on x9
        iss(9); tick(); idle(); #1;
        chk("x9 cnt", 64'(busy_cnt), 64'd1);
        wb(9, 32'h99); iss(9); rs_addr = {5'd0, 5'd9}; #1;
        chk("x9 same-cycle rdy", 64'(issue_rdy), 64'd1);
        tick(); idle(); #1;
        chk("x9 still busy cnt", 64'(busy_cnt), 64'd1);
        chk("x9 still busy", 64'(rs_busy[0]), 64'd1);
        chk("x9 data", 64'(rs_data[31:0]), 64'h99);

        // retire x9 while issuing x10: net zero
        wb(9, 32'h999); iss(10); tick(); idle();
        rs_addr = {5'd10, 5'd9}; #1;
        chk("swap cnt", 64'(busy_cnt), 64'd1);
        chk("swap busy", 64'(rs_busy), 64'b10);
        chk("swap data", 64'(rs_data[31:0]), 64'h999);

        // write without scoreboard leaves count alone
        wb(4, 32'd44); tick(); idle(); #1;
        chk("free wb cnt", 64'(busy_cnt), 64'd1);
        wb(10, 32'd100); tick(); idle(); #1;
        chk("x10 retire cnt", 64'(busy_cnt), 64'd0);

        // fill the scoreboard to its maximum
        for (int r = 1; r < NREGS; r++) begin
            iss(r); tick();
        end
        idle(); #1;
        chk("full cnt", 64'(busy_cnt), 64'd31);
        iss(5); #1;
        chk("full waw", 64'(issue_rdy), 64'd0);
        tick(); idle(); #1;
        chk("full cnt hold", 64'(busy_cnt), 64'd31);
        for (int r = 1; r <= 15; r++) begin
            wb(r, 32'(r * 3)); tick();
        end
        idle(); rs_addr = {5'd2, 5'd15}; #1;
        chk("half cnt", 64'(busy_cnt), 64'd16);
        chk("half data", 64'(rs_data), {32'd6, 32'd45});

        // asynchronous reset mid-cycle with state populated
        rs_addr = {5'd20, 5'd1}; iss(20);
        rst_n = 1'b0; #1;
        chk("midreset rs_data", 64'(rs_data), 64'd0);
        chk("midreset rs_busy", 64'(rs_busy), 64'd0);
        chk("midreset cnt", 64'(busy_cnt), 64'd0);
        chk("midreset rdy", 64'(issue_rdy), 64'd1);
        idle();
        tick();
        rst_n = 1'b1;
        iss(5); tick(); idle(); #1;
        chk("post-reset issue cnt", 64'(busy_cnt), 64'd1);
        wb(5, 32'd7); tick(); idle(); #1;
        chk("post-reset retire cnt", 64'(busy_cnt), 64'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
